// File: rtl/push_feedback_led_if.sv
// rtl/push_feedback_led_if.sv - button pulse / LED feedback bundle for push_feedback_led
interface push_feedback_led_if #(
    parameter int NUM_LANES = 4
);
    logic [NUM_LANES-1:0] i_fPush;
    logic                 i_ClrCnt;
    logic [NUM_LANES-1:0] o_Led;
    logic [NUM_LANES-1:0] o_Busy;
    logic [7:0]           o_HitCnt;

    modport master (
        output i_fPush,
        output i_ClrCnt,
        input  o_Led,
        input  o_Busy,
        input  o_HitCnt
    );

    modport slave (
        input  i_fPush,
        input  i_ClrCnt,
        output o_Led,
        output o_Busy,
        output o_HitCnt
    );
endinterface

// File: rtl/push_feedback_led.sv
// rtl/push_feedback_led.sv - per-lane fixed-length LED flash with dark gap and saturating hit count
// Optional feature: `PUSH_FEEDBACK_RETRIGGER_EN restarts the on-time when a pulse lands during a flash.
module push_feedback_led #(
    parameter int NUM_LANES = 4,
    parameter int HOLD_MAX  = 5_000_000,
    parameter int GAP_MAX   = 500_000
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    push_feedback_led_if.slave  btn_bus
);

    localparam int CNT_MAX = (HOLD_MAX > GAP_MAX) ? HOLD_MAX : GAP_MAX;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [NUM_LANES-1:0] lane_hit;
    logic [NUM_LANES-1:0] led_vec;
    logic [NUM_LANES-1:0] busy_vec;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [1:0]       state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             pend_q, pend_d;
        logic             hit;
        logic             push;
        logic             led_q, busy_q;

        assign push = btn_bus.i_fPush[g];

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            pend_d  = pend_q;
            hit     = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (push) begin
                        state_d = S_ON;
                        cnt_d   = '0;
                        hit     = 1'b1;
                    end
                end
                S_ON: begin
`ifdef PUSH_FEEDBACK_RETRIGGER_EN
                    if (push) begin
                        cnt_d = '0;
                        hit   = 1'b1;
                    end else
`endif
                    if (cnt_q == HOLD_LAST) begin
                        state_d = S_GAP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_GAP: begin
                    // A pulse on the final gap cycle starts the next flash directly.
                    if (cnt_q == GAP_LAST) begin
                        cnt_d  = '0;
                        pend_d = 1'b0;
                        if (pend_q || push) begin
                            state_d = S_ON;
                            hit     = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (push) begin
                            pend_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end
            endcase
        end

        always_ff @(posedge i_Clk) begin
            if (i_Rst) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                pend_q  <= 1'b0;
                led_q   <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pend_q  <= pend_d;
                led_q   <= (state_d == S_ON);
                busy_q  <= (state_d != S_IDLE);
            end
        end

        assign lane_hit[g] = hit;
        assign led_vec[g]  = led_q;
        assign busy_vec[g] = busy_q;
    end

    logic [15:0] hit_sum;
    logic [15:0] cnt_sum;
    logic [7:0]  hit_cnt_q, hit_cnt_d;

    always_comb begin
        hit_sum = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            hit_sum = hit_sum + 16'(lane_hit[i]);
        end
        cnt_sum   = 16'(hit_cnt_q) + hit_sum;
        hit_cnt_d = (cnt_sum > 16'd255) ? 8'hFF : cnt_sum[7:0];
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst || btn_bus.i_ClrCnt) begin
            hit_cnt_q <= '0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign btn_bus.o_Led    = led_vec;
    assign btn_bus.o_Busy   = busy_vec;
    assign btn_bus.o_HitCnt = hit_cnt_q;

endmodule

// File: doc/push_feedback_led.md
# push_feedback_led

Output-side companion to the one-push button conditioner. Takes the 1-cycle `fPush` pulses from up to `NUM_LANES` conditioned buttons and turns each one into a fixed-length, human-visible LED flash, followed by a guaranteed dark gap. It also keeps a saturating count of accepted hits. It sits between the button front-end and the DE1-SoC LEDR pins and gives player feedback in the rhythm game.

## Interface
- `NUM_LANES`, 4: number of independent button/LED lanes.
- `HOLD_MAX`, 5_000_000: LED on-time in clock cycles (100 ms at 50 MHz); must be ≥ 1.
- `GAP_MAX`, 500_000: minimum LED off-time between flashes in cycles (10 ms); must be ≥ 1.
- `i_Clk`  input  1  system clock; the only clock.
- `i_Rst`  input  1  reset, synchronous, active-high.
- `i_fPush`  input  NUM_LANES  per-lane 1-cycle push pulse, active-high.
- `i_ClrCnt`  input  1  synchronous clear of `o_HitCnt`.
- `o_Led`  output  NUM_LANES  per-lane LED drive, registered, active-high.
- `o_Busy`  output  NUM_LANES  per-lane: lane is not IDLE (ON or GAP), registered.
- `o_HitCnt`  output  8  saturating count of accepted hits across all lanes, registered.

## Operation
- Each lane has its own FSM with states S_IDLE, S_ON and S_GAP, a cycle counter sized for max(HOLD_MAX, GAP_MAX), and a 1-bit pending flag.
- S_IDLE:
  - A pulse goes to S_ON with the counter at 0 and counts as an accepted hit.
- S_ON:
  - The counter increments each cycle.
  - At count HOLD_MAX−1 the lane goes to S_GAP with the counter at 0.
  - A pulse in S_ON is handled as described under Configuration.
- S_GAP:
  - The counter increments each cycle.
  - A pulse sets pending. If pending is already set, the pulse is dropped and not counted.
  - At count GAP_MAX−1 the lane goes to S_ON with the counter at 0 if pending is set or a pulse arrives that same cycle. This counts as one accepted hit, and pending is cleared.
  - Otherwise the lane goes to S_IDLE.
- Illegal state returns to S_IDLE.
- `o_Led` = (state == S_ON); `o_Busy` = (state != S_IDLE). Both are registered.
- `o_HitCnt`:
  - Adds the number of lanes accepting a hit in that cycle (0..NUM_LANES), so simultaneous lanes all count.
  - Saturates at 255 and never wraps.
  - `i_ClrCnt` has priority: the count becomes 0 and that cycle's increments are discarded.

## Timing
- Reset: all lanes go to S_IDLE, counters and pending clear to 0, `o_Led` = 0, `o_Busy` = 0, `o_HitCnt` = 0. A reset mid-flash forces `o_Led` low at the next edge.
- Latency: a pulse sampled at edge k gives `o_Led` = 1 after edge k. The `o_HitCnt` update also appears after edge k.
- An LED is high for exactly HOLD_MAX cycles per flash, then low for at least GAP_MAX cycles.
- `o_Busy` stays high for HOLD_MAX + GAP_MAX cycles after an isolated pulse.
- Lanes are fully independent; simultaneous pulses on any subset of lanes are all handled in the same cycle.
- A pulse arriving in the same cycle as a state-ending count is evaluated against the current state: last S_ON cycle follows the S_ON rule; last S_GAP cycle starts a new flash.

## Configuration
- `PUSH_FEEDBACK_RETRIGGER_EN` defined:
  - A pulse in S_ON resets the counter to 0, so the lane stays ON for a further HOLD_MAX cycles.
  - The retrigger counts as an accepted hit.
- `PUSH_FEEDBACK_RETRIGGER_EN` undefined:
  - A pulse in S_ON is dropped and not counted.
  - The flash length is unaffected.

## Test plan
All scenarios use `HOLD_MAX`=8, `GAP_MAX`=4, `NUM_LANES`=4.
- Isolated pulse on lane 0 → `o_Led[0]` high for exactly 8 cycles starting 1 cycle after the pulse; `o_Busy[0]` high for 12 cycles; `o_HitCnt`=1.
- Pulses on lanes 0–3 in the same cycle → all four LEDs rise together; `o_HitCnt`=4 after one edge.
- Pulse at cycle 4 of S_ON → with the macro, the LED stays high for 4+8=12 cycles total and `o_HitCnt`=2; without it, the LED is high for 8 cycles and `o_HitCnt`=1.
- Two pulses during S_GAP → one new 8-cycle flash starts right after the gap; the second pulse is dropped; `o_HitCnt` increases by 1.
- 300 spaced pulses with an `i_ClrCnt` pulse coinciding with a hit → `o_HitCnt` sticks at 255, then reads 0 the cycle after the clear.
- `i_Rst` asserted for 1 cycle mid-flash → `o_Led`, `o_Busy` and `o_HitCnt` all 0 after that edge; the next pulse gives a full 8-cycle flash.
